// File: rtl/ahb_to_sram_bridge_if.sv
// rtl/ahb_to_sram_bridge_if.sv - AHB-Lite slave bus plus single-port SRAM port bundle
interface ahb_to_sram_bridge_if #(
  parameter int AW = 15
);
  logic          HSEL;
  logic          HREADY;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [AW-1:0] HADDR;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [31:0]   SRAMRDATA;
  logic [AW-3:0] SRAMADDR;
  logic [3:0]    SRAMWEN;
  logic [31:0]   SRAMWDATA;
  logic          SRAMCS;

  modport slave (
    input  HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA, SRAMRDATA,
    output HREADYOUT, HRESP, HRDATA, SRAMADDR, SRAMWEN, SRAMWDATA, SRAMCS
  );

  modport master (
    output HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA, SRAMRDATA,
    input  HREADYOUT, HRESP, HRDATA, SRAMADDR, SRAMWEN, SRAMWDATA, SRAMCS
  );
endinterface

// File: rtl/ahb_to_sram_bridge.sv
// rtl/ahb_to_sram_bridge.sv - zero-wait AHB-Lite to synchronous SRAM bridge
// Writes colliding with a read address phase park in a one-entry buffer; reads forward from it.
module ahb_to_sram_bridge #(
  parameter int AW = 15
) (
  input logic                 HCLK,
  input logic                 HRESETn,
  ahb_to_sram_bridge_if.slave bus
);
  logic          rd_ap, wr_ap;
  logic [3:0]    ap_mask;
  logic [AW-3:0] ap_word;
  logic [3:0]    fwd_mask;

  logic          wr_dp;
  logic [AW-3:0] dp_addr;
  logic [3:0]    dp_mask;
  logic          buf_pend;
  logic [AW-3:0] buf_addr;
  logic [3:0]    buf_mask;
  logic [31:0]   buf_data;
  logic [3:0]    rd_merge;

  assign rd_ap   = bus.HSEL & bus.HREADY & bus.HTRANS[1] & ~bus.HWRITE;
  assign wr_ap   = bus.HSEL & bus.HREADY & bus.HTRANS[1] & bus.HWRITE;
  assign ap_word = bus.HADDR[AW-1:2];

  always_comb begin
    ap_mask = 4'b1111;
    case (bus.HSIZE)
      3'd0:    ap_mask = 4'b0001 << bus.HADDR[1:0];
      3'd1:    ap_mask = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: ap_mask = 4'b1111;
    endcase
  end

  always_comb begin
    fwd_mask = 4'b0000;
    if (buf_pend && (buf_addr == ap_word))
      fwd_mask = buf_mask;
    else if (wr_dp && (dp_addr == ap_word))
      fwd_mask = dp_mask;
  end

  // Read address phase always owns the SRAM; a write data phase then yields to the buffer.
  always_comb begin
    bus.SRAMCS   = 1'b0;
    bus.SRAMWEN  = 4'b0000;
    bus.SRAMADDR = '0;
    if (rd_ap) begin
      bus.SRAMCS   = 1'b1;
      bus.SRAMADDR = ap_word;
    end else if (wr_dp) begin
      bus.SRAMCS   = 1'b1;
      bus.SRAMWEN  = dp_mask;
      bus.SRAMADDR = dp_addr;
    end else if (buf_pend) begin
      bus.SRAMCS   = 1'b1;
      bus.SRAMWEN  = buf_mask;
      bus.SRAMADDR = buf_addr;
    end
  end

  assign bus.SRAMWDATA = wr_dp ? bus.HWDATA : buf_data;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;

  always_comb begin
    bus.HRDATA = bus.SRAMRDATA;
    for (int i = 0; i < 4; i++)
      if (rd_merge[i]) bus.HRDATA[8*i +: 8] = buf_data[8*i +: 8];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_dp    <= 1'b0;
      dp_addr  <= '0;
      dp_mask  <= 4'b0000;
      buf_pend <= 1'b0;
      buf_addr <= '0;
      buf_mask <= 4'b0000;
      buf_data <= 32'h0;
      rd_merge <= 4'b0000;
    end else begin
      if (bus.HREADY) begin
        wr_dp <= wr_ap;
        if (wr_ap) begin
          dp_addr <= ap_word;
          dp_mask <= ap_mask;
        end
      end
      if (rd_ap && wr_dp) begin
        buf_pend <= 1'b1;
        buf_addr <= dp_addr;
        buf_mask <= dp_mask;
        buf_data <= bus.HWDATA;
      end else if (!rd_ap && !wr_dp && buf_pend) begin
        buf_pend <= 1'b0;
      end
      rd_merge <= rd_ap ? fwd_mask : 4'b0000;
    end
  end

  // A buffered write is always followed by a read data phase, never a write one.
  assert property (@(posedge HCLK) disable iff (!HRESETn) !(wr_dp && buf_pend));
endmodule

// File: tb/tb_ahb_to_sram_bridge.sv
// tb/tb_ahb_to_sram_bridge.sv - directed plus random bench against a byte-array memory model
module tb_ahb_to_sram_bridge;
  logic HCLK;
  logic HRESETn;
  int   total = 0;
  int   bad = 0;

  ahb_to_sram_bridge_if #(.AW(15)) bus ();
  ahb_to_sram_bridge #(.AW(15)) dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // Environment: synchronous SRAM, registered read data.
  logic [31:0] sram_mem [0:8191];
  logic [31:0] sram_rdata;
  assign bus.SRAMRDATA = sram_rdata;
  initial begin
    for (int i = 0; i < 8192; i++) sram_mem[i] = init_word(i);
    sram_rdata = 32'h0;
    forever begin
      @(posedge HCLK);
      if (bus.SRAMCS) begin
        if (bus.SRAMWEN == 4'b0000)
          sram_rdata <= sram_mem[bus.SRAMADDR];
        else
          for (int b = 0; b < 4; b++)
            if (bus.SRAMWEN[b]) sram_mem[bus.SRAMADDR][8*b +: 8] <= bus.SRAMWDATA[8*b +: 8];
      end
    end
  end

  // Reference: flat byte memory updated in bus order.
  logic [7:0] ref_mem [0:32767];

  task automatic ref_write(input logic [14:0] addr, input logic [2:0] size, input logic [31:0] data);
    int n;
    int base;
    n = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
    base = int'(addr) & ~(n - 1);
    for (int i = 0; i < n; i++) ref_mem[base + i] = data[8*((base + i) % 4) +: 8];
  endtask

  function automatic logic [31:0] ref_word(input logic [14:0] addr);
    int b;
    b = int'(addr) & ~3;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic        pend_write = 1'b0;
  logic [31:0] pend_wdata = 32'h0;
  logic        last_acc = 1'b0;
  logic        obs_cs;
  logic [3:0]  obs_wen;
  logic [12:0] obs_addr;

  // One bus cycle: drive address phase (and data of the previous write), check on the far side of the edge.
  task automatic step(input logic sel, input logic [1:0] trans, input logic wr, input logic [2:0] size,
                      input logic [14:0] addr, input logic [31:0] wdata, input logic rdy);
    logic acc;
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    bus.HADDR  = addr;
    bus.HREADY = rdy;
    bus.HWDATA = pend_write ? pend_wdata : $urandom;
    #1;
    obs_cs   = bus.SRAMCS;
    obs_wen  = bus.SRAMWEN;
    obs_addr = bus.SRAMADDR;
    @(posedge HCLK);
    #1;
    chk("hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    chk("hresp", {31'h0, bus.HRESP}, 32'h0);
    acc = sel & rdy & trans[1];
    if (rdy) pend_write = acc & wr;
    if (acc) begin
      if (wr) begin
        pend_wdata = wdata;
        ref_write(addr, size, wdata);
      end else begin
        chk($sformatf("rd@%h", addr), bus.HRDATA, ref_word(addr));
      end
    end
    last_acc = acc;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, 3'd0, 15'h0, 32'h0, 1'b1);
  endtask

  task automatic wr(input logic [14:0] a, input logic [2:0] s, input logic [31:0] d);
    step(1'b1, 2'b10, 1'b1, s, a, d, 1'b1);
  endtask

  task automatic rd(input logic [14:0] a);
    step(1'b1, 2'b10, 1'b0, 3'd2, a, 32'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] saved;
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic        rdy;

    for (int b = 0; b < 32768; b++) begin
      w = init_word(b / 4);
      ref_mem[b] = w[8*(b % 4) +: 8];
    end
    HRESETn = 1'b0;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HSIZE = 3'd0;
    bus.HADDR = '0; bus.HREADY = 1'b1; bus.HWDATA = 32'h0;
    #2;
    chk("rst_cs", {31'h0, bus.SRAMCS}, 32'h0);
    chk("rst_wen", {28'h0, bus.SRAMWEN}, 32'h0);
    chk("rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    chk("rst_hresp", {31'h0, bus.HRESP}, 32'h0);
    repeat (2) @(posedge HCLK);
    #3 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // 1: plain write then read
    wr(15'h0010, 3'd2, 32'hDEADBEEF);
    idle();
    chk("t1_cs", {31'h0, obs_cs}, 32'h1);
    chk("t1_wen", {28'h0, obs_wen}, 32'hF);
    chk("t1_addr", {19'h0, obs_addr}, 32'h4);
    rd(15'h0010);
    chk("t1_data", bus.HRDATA, 32'hDEADBEEF);

    // 2: write immediately followed by read of same word
    idle();
    wr(15'h0020, 3'd2, 32'h11223344);
    rd(15'h0020);
    chk("t2_rdwen", {28'h0, obs_wen}, 32'h0);
    chk("t2_rdaddr", {19'h0, obs_addr}, 32'h8);
    chk("t2_data", bus.HRDATA, 32'h11223344);
    idle();
    chk("t2_drain_wen", {28'h0, obs_wen}, 32'hF);
    chk("t2_drain_addr", {19'h0, obs_addr}, 32'h8);

    // 3: byte + half writes merged into a word read
    wr(15'h0031, 3'd0, 32'h0000AA00);
    wr(15'h0032, 3'd1, 32'hBBCC0000);
    chk("t3_wen_byte", {28'h0, obs_wen}, 32'h2);
    rd(15'h0030);
    chk("t3_data", {8'h0, bus.HRDATA[31:8]}, 32'h00BBCCAA);
    idle();
    chk("t3_wen_half", {28'h0, obs_wen}, 32'hC);

    // 4: buffer held across back-to-back reads
    wr(15'h0040, 3'd2, 32'h0BADF00D);
    rd(15'h0044);
    rd(15'h0048);
    chk("t4_hold_wen", {28'h0, obs_wen}, 32'h0);
    rd(15'h0040);
    chk("t4_hold2_wen", {28'h0, obs_wen}, 32'h0);
    chk("t4_fwd", bus.HRDATA, 32'h0BADF00D);
    idle();
    chk("t4_drain_wen", {28'h0, obs_wen}, 32'hF);
    chk("t4_drain_addr", {19'h0, obs_addr}, 32'h10);
    idle();
    chk("t4_idle_cs", {31'h0, obs_cs}, 32'h0);

    // 5: reset discards a pending buffered write
    saved = ref_word(15'h0050);
    wr(15'h0050, 3'd2, 32'hCAFEF00D);
    rd(15'h0060);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    HRESETn = 1'b0;
    #1;
    chk("t5_cs", {31'h0, bus.SRAMCS}, 32'h0);
    chk("t5_wen", {28'h0, bus.SRAMWEN}, 32'h0);
    @(posedge HCLK);
    #2 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    pend_write = 1'b0;
    last_acc = 1'b0;
    ref_write(15'h0050, 3'd2, saved);
    idle();
    rd(15'h0050);
    chk("t5_old", bus.HRDATA, saved);

    // 6: HREADY low from another slave
    idle();
    step(1'b1, 2'b10, 1'b0, 3'd2, 15'h0010, 32'h0, 1'b0);
    chk("t6_cs", {31'h0, obs_cs}, 32'h0);
    step(1'b1, 2'b10, 1'b1, 3'd2, 15'h0010, 32'h12345678, 1'b0);
    chk("t6_cs_w", {31'h0, obs_cs}, 32'h0);
    idle();
    chk("t6_idle_cs", {31'h0, obs_cs}, 32'h0);
    rd(15'h0010);

    // Random traffic on a small window to force collisions and forwarding
    for (int n = 0; n < 400; n++) begin
      tr  = 2'($urandom_range(0, 3));
      sz  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      rdy = last_acc ? 1'b1 : ($urandom_range(0, 5) != 0);
      step($urandom_range(0, 7) != 0, tr, 1'($urandom_range(0, 1)), sz,
           15'($urandom_range(0, 127)), $urandom, rdy);
    end
    repeat (3) idle();
    for (int a = 0; a < 128; a += 4) rd(15'(a));
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
